// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor and its neighbouring adder bench.
package sub_pkg;

  localparam int unsigned SUB_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: num1 - num2, LSB first, with start/busy/done handshake.
module serial_sub
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             d_bit, b_bit, last_bit;

  full_sub u_full_sub (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (borrow),
    .d   (d_bit),
    .bout(b_bit)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nx = ST_DONE;
      end
      ST_DONE:  begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  // The final difference bit is folded straight into out so it is valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      count  <= '0;
      out    <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr   <= num1;
            b_sr   <= num2;
            borrow <= 1'b0;
            count  <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          borrow <= b_bit;
          count  <= count + 1'b1;
          if (last_bit) begin
            out  <= {d_bit, res_sr[WIDTH-1:1]};
            bout <= b_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial unsigned subtractor, the inverse-direction counterpart of the team's combinational 4-bit adder (num1/num2 in, out/cout out).
- Computes num1 - num2 one bit per clock, LSB first, and returns the WIDTH-bit difference plus borrow-out.
- Uses a start/busy/done handshake.
- Sits beside the adder in the arithmetic lab block, and its result is checked against the adder: {bout,out} + num2 reconstructs num1.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..16)

Ports:
clk    input   1      system clock, all logic on rising edge
rst_n  input   1      synchronous reset, active-low
start  input   1      request; sampled only in IDLE
num1   input   WIDTH  minuend, captured on the accepted start
num2   input   WIDTH  subtrahend, captured on the accepted start
busy   output  1      high while the subtraction is in progress (SHIFT state)
done   output  1      one-cycle pulse; out/bout are valid from this cycle on
out    output  WIDTH  difference (num1 - num2) mod 2^WIDTH
bout   output  1      borrow-out; 1 iff num1 < num2 (unsigned)

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is synchronous and active-low. It is sampled only on the rising edge of clk and has priority over all other logic.
- Reset values:
  - state=IDLE.
  - busy=0, done=0, out=0, bout=0.
  - Internal operand shift registers, borrow flop and bit counter all cleared.
- State IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch num1 into shift register A and num2 into B, clear borrow, set count=0, go to SHIFT.
  - out/bout keep their previous result and do not change on accept.
- State SHIFT:
  - busy=1. Each edge processes bit a=A[0], b=B[0], borrow-in c.
  - Difference bit d = a^b^c.
  - Borrow-out c' = (~a&b) | (~(a^b)&c).
  - d is shifted into the MSB of the result register. A and B shift right. count increments.
  - When count reaches WIDTH-1 on that edge (the WIDTH-th bit is processed), go to DONE.
- State DONE:
  - busy=0, done=1 for exactly one cycle.
  - out = result register, bout = final borrow.
  - Next edge returns unconditionally to IDLE.
- Latency:
  - start accepted on edge N, so busy is high for cycles N+1..N+WIDTH.
  - done is high in the cycle after edge N+WIDTH.
  - Next start is accepted on edge N+WIDTH+2 at the earliest.
- out/bout are registered:
  - Updated only on the entry into DONE.
  - Held stable until the next completed operation.
- start while busy or during DONE: ignored. No queuing, no effect on the operation in flight.
- num1/num2 changes after the accept edge have no effect.
- Reset mid-operation (rst_n=0 during SHIFT or DONE): next edge forces IDLE, all outputs 0. No done pulse is emitted for the aborted operation.
- Arithmetic is purely unsigned:
  - {bout,out} = (2^WIDTH + num1 - num2) with bout inverted relative to bit WIDTH of that sum.
  - Equivalently, bout=1 exactly when num1<num2.
- Counter width is clog2(WIDTH)+1 bits. No wrap occurs because the counter is cleared on every accept.

Decomposition:
- Shared package sub_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Default width constant SUB_WIDTH=4, shared with the adder bench.
- One sub-module: full_sub (combinational 1-bit full subtractor: a, b, bin -> d, bout). Instantiated once inside serial_sub.
- FSM, shift registers and counter stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with start=1 -> busy=0, done=0, out=0, bout=0, and no operation starts.
2. Basic case, num1=5, num2=3, start pulsed 1 cycle:
   - busy high for exactly 4 cycles.
   - done pulses once.
   - out=4'b0010, bout=0.
3. Borrow cases:
   - num1=3, num2=5 -> out=4'b1110, bout=1.
   - num1=0, num2=15 -> out=4'b0001, bout=1.
   - num1=15, num2=0 -> out=4'b1111, bout=0.
4. Protocol robustness:
   - Start 9-4, then pulse start with 1-2 during busy and again during done -> single result out=5, bout=0.
   - Inputs changed mid-operation do not affect the result.
5. Reset mid-operation: start 12-7, drop rst_n on the 2nd busy cycle -> IDLE next edge, outputs 0, no done pulse; a fresh 12-7 afterwards gives out=5, bout=0.
6. Exhaustive sweep, mirroring the adder bench:
   - For all i,j in 0..15, run back-to-back operations.
   - Compare {bout,out} against (i>=j ? {1'b0, i-j} : {1'b1, (16+i-j)}).
   - Print OK/ERRO per case; zero ERRO lines are required.
